fluid_dispense_ctrl: RTL and testbench

FLUID_DISPENSE_CTRL -- requirements
Module: fluid_dispense_ctrl

---
 rtl/fluid_ctrl_pkg.sv | 24 ++
 rtl/fluid_dispense_ctrl_step_timer.sv | 42 ++++
 rtl/fluid_dispense_ctrl.sv | 113 +++++++++++
 tb/tb_fluid_dispense_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fluid_ctrl_pkg.sv
// Shared types and default timing constants for the fluid dispense controller.
// Combinational definitions only; no latency, no flow control.
// Imported by the controller top and its step timer.
package fluid_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRIME   = 3'd1,
        PUMP    = 3'd2,
        SETTLE  = 3'd3,
        COLLECT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam int DEF_STEP_DIV    = 4;
    localparam int DEF_SETTLE_CYC  = 16;
    localparam int DEF_COLLECT_CYC = 8;
    localparam int DEF_VOL_W       = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fluid_dispense_ctrl_step_timer.sv
// Pump step divider: counts 0..STEP_DIV-1 while enabled, pulses step on the last count.
// Step is registered; it is high in the cycle the divider holds STEP_DIV-1.
// No backpressure; clr dominates en and parks the divider at zero.
module step_timer
    import fluid_ctrl_pkg::*;
#(
    parameter int STEP_DIV = DEF_STEP_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    // en/clr describe the coming cycle, so the pulse can be a flop output.
    always_comb begin
        div_nxt = div;
        if (clr) begin
            div_nxt = '0;
        end else if (en) begin
            div_nxt = (div == LAST) ? '0 : div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div  <= '0;
            step <= 1'b0;
        end else begin
            div  <= div_nxt;
            step <= en && !clr && (div_nxt == LAST);
        end
    end

endmodule

// File: rtl/fluid_dispense_ctrl.sv
// Microfluidic dispense sequencer: prime, pump vol steps, settle, collect, done.
// All outputs registered; first output change one cycle after an accepted start.
// No backpressure; start is ignored while busy, abort cancels any active run.
module fluid_dispense_ctrl
    import fluid_ctrl_pkg::*;
#(
    parameter int STEP_DIV    = DEF_STEP_DIV,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int COLLECT_CYC = DEF_COLLECT_CYC,
    parameter int VOL_W       = DEF_VOL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VOL_W-1:0] vol,
    input  logic             abort,
    output logic             inlet_valve,
    output logic             pump_step,
    output logic             outlet_valve,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_MAX = max2(SETTLE_CYC, COLLECT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    state_t           state_nxt;
    logic [VOL_W-1:0] rem;
    logic [VOL_W-1:0] rem_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;
    logic             tmr_en;
    logic             tmr_clr;

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (tmr_en),
        .clr  (tmr_clr),
        .step (pump_step)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (vol != '0) state_nxt = PRIME;
                    else           err_nxt   = 1'b1;
                end
            end
            PRIME:   state_nxt = PUMP;
            // pump_step marks the last divider cycle; rem counts steps still owed.
            PUMP:    if (pump_step && rem == VOL_W'(1)) state_nxt = SETTLE;
            SETTLE:  if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = COLLECT;
            COLLECT: if (cnt == CNT_W'(COLLECT_CYC - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end
    end

    always_comb begin
        rem_nxt = rem;
        if (state_nxt == IDLE) begin
            rem_nxt = '0;
        end else if (state == IDLE && state_nxt == PRIME) begin
            rem_nxt = vol;
        end else if (state == PUMP && pump_step) begin
            rem_nxt = rem - VOL_W'(1);
        end

        cnt_nxt = '0;
        if (state_nxt == state && (state == SETTLE || state == COLLECT)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end

        tmr_en  = (state_nxt == PUMP);
        tmr_clr = (state != PUMP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= '0;
            cnt          <= '0;
            inlet_valve  <= 1'b0;
            outlet_valve <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            rem          <= rem_nxt;
            cnt          <= cnt_nxt;
            inlet_valve  <= (state_nxt == PRIME) || (state_nxt == PUMP);
            outlet_valve <= (state_nxt == COLLECT);
            busy         <= (state_nxt != IDLE) && (state_nxt != DONE);
            done         <= (state_nxt == DONE);
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fluid_dispense_ctrl.sv
// Directed bench for fluid_dispense_ctrl with default timing (STEP_DIV=4, SETTLE=16, COLLECT=8).
// Cycle 0 is the cycle in which start is presented; outputs are sampled on the falling edge.
module tb_fluid_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] vol = 8'd0;
    logic       abort = 1'b0;
    logic       inlet_valve, pump_step, outlet_valve, busy, done, err;

    int total = 0;
    int bad   = 0;

    fluid_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vol          (vol),
        .abort        (abort),
        .inlet_valve  (inlet_valve),
        .pump_step    (pump_step),
        .outlet_valve (outlet_valve),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Vector order: {busy, inlet_valve, pump_step, outlet_valve, done, err}
    function automatic logic [5:0] outs();
        return {busy, inlet_valve, pump_step, outlet_valve, done, err};
    endfunction

    // Expected outputs of an undisturbed run of v steps started at cycle 0.
    function automatic logic [5:0] exp_run(input int v, input int c);
        int pe, os, oe;
        logic b, i, p, o, d;
        pe = 1 + 4 * v;
        os = pe + 17;
        oe = os + 7;
        b = (c >= 1) && (c <= oe);
        i = (c >= 1) && (c <= pe);
        p = (c >= 5) && (c <= pe) && (((c - 1) % 4) == 0);
        o = (c >= os) && (c <= oe);
        d = (c == oe + 1);
        return {b, i, p, o, d, 1'b0};
    endfunction

    // Apply inputs for one cycle (called just after a rising edge), sample at the falling edge.
    task automatic cycle(input logic s, input logic [7:0] v, input logic a, output logic [5:0] got);
        start = s;
        vol   = v;
        abort = a;
        @(negedge clk);
        got = outs();
        @(posedge clk);
        #1;
    endtask

    task automatic run_normal(input string name, input int v, input int ncyc);
        logic [5:0] g;
        int pulses;
        pulses = 0;
        for (int c = 0; c <= ncyc; c++) begin
            cycle(c == 0, 8'(v), 1'b0, g);
            if (g[3]) pulses++;
            chk($sformatf("%s c%0d", name, c), 32'(g), 32'(exp_run(v, c)));
        end
        chk($sformatf("%s pulses", name), 32'(pulses), 32'(v));
    endtask

    initial begin
        logic [5:0] g;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 8'd0, 1'b0, g);
        chk("idle outs", 32'(g), 32'd0);

        run_normal("norm", 3, 42);

        // Rejected request: vol == 0.
        for (int c = 0; c <= 5; c++) begin
            cycle(c == 0, 8'd0, 1'b0, g);
            chk($sformatf("rej c%0d", c), 32'(g), (c == 1) ? 32'h01 : 32'h00);
        end

        // Abort during PUMP at cycle 8.
        for (int c = 0; c <= 45; c++) begin
            cycle(c == 0, 8'd3, c == 8, g);
            chk($sformatf("abort c%0d", c), 32'(g),
                (c <= 8) ? 32'(exp_run(3, c)) : ((c == 9) ? 32'h01 : 32'h00));
        end

        // Abort while idle does nothing and blocks a same-cycle start.
        for (int c = 0; c <= 3; c++) begin
            cycle(c == 0, 8'd3, c == 0, g);
            chk($sformatf("idle abort c%0d", c), 32'(g), 32'h00);
        end

        run_normal("max", 255, 1050);

        // Starts at cycle 10 (vol=7) and 38 (DONE) ignored; start at 39 accepted.
        for (int c = 0; c <= 80; c++) begin
            cycle((c == 0) || (c == 10) || (c == 38) || (c == 39),
                  (c == 10) ? 8'd7 : 8'd3, 1'b0, g);
            chk($sformatf("ign c%0d", c), 32'(g),
                (c <= 38) ? 32'(exp_run(3, c)) : 32'(exp_run(3, c - 39)));
        end

        // Reset asserted at cycle 32 (during COLLECT), released at cycle 34.
        for (int c = 0; c <= 50; c++) begin
            if (c == 32) rst = 1'b1;
            if (c == 34) rst = 1'b0;
            cycle(c == 0, 8'd3, 1'b0, g);
            chk($sformatf("rstmid c%0d", c), 32'(g), (c < 32) ? 32'(exp_run(3, c)) : 32'h00);
        end

        run_normal("after rst", 3, 42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
